// File: rtl/uart_rx_core_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_core_if
// Description : Interface bundle for the UART receive front end.
//               Carries the raw serial line and the deframed byte and status
//               signals that go to the bus-facing UART register block.
//   rx        : raw asynchronous serial input; idle high
//   rxdata    : last correctly framed byte, LSB received first
//   rxstrobe  : one-cycle pulse; rxdata valid and newly updated
//   frame_err : one-cycle pulse; stop bit sampled low
//   busy      : high while a frame is being received
//   master    : receiver side (uart_rx_core)
//   slave     : line driver / consumer side
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_core_if;
    logic       rx;
    logic [7:0] rxdata;
    logic       rxstrobe;
    logic       frame_err;
    logic       busy;

    modport master (
        input  rx,
        output rxdata,
        output rxstrobe,
        output frame_err,
        output busy
    );

    modport slave (
        output rx,
        input  rxdata,
        input  rxstrobe,
        input  frame_err,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_core
// Description : UART 8N1 serial receive front end. Synchronises the raw RX
//               line, detects start edges, samples every bit mid-period and
//               deframes characters. Good bytes are presented with a
//               one-cycle strobe; a low stop bit gives a one-cycle framing
//               error pulse and the receiver then waits out the line break.
// Parameters  : DIVIDER - clock cycles per bit period (4..65535)
// Ports       : clk             - system clock, rising edge
//               rst_n           - asynchronous active-low reset
//               bus.rx          - raw serial input (idle high)
//               bus.rxdata      - last correctly framed byte
//               bus.rxstrobe    - one-cycle pulse, rxdata newly updated
//               bus.frame_err   - one-cycle pulse, stop bit sampled low
//               bus.busy        - high whenever not idle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_core #(
    parameter int DIVIDER = 139
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    uart_rx_core_if.master bus
);

    localparam int            CW       = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam logic [CW-1:0] C_RELOAD = CW'(DIVIDER - 1);
    localparam logic [CW-1:0] C_HALF   = CW'((DIVIDER - 1) / 2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    // Line conditioning
    logic          sync1_q;
    logic          rx_s_q;
    logic          rx_prev_q;
    logic [1:0]    sync_vld_q;
    logic          armed_q;
    logic          armed_d;

    // Receiver state
    state_t        state_q,     state_d;
    logic [2:0]    bitcnt_q,    bitcnt_d;
    logic [CW-1:0] baud_q,      baud_d;
    logic [7:0]    shift_q,     shift_d;
    logic [7:0]    rxdata_q,    rxdata_d;
    logic          rxstrobe_q,  rxstrobe_d;
    logic          frame_err_q, frame_err_d;

    logic          w_start_edge;
    logic          w_sample;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
            sync_vld_q  <= 2'b00;
            armed_q     <= 1'b0;
            state_q     <= S_IDLE;
            bitcnt_q    <= 3'd0;
            baud_q      <= '0;
            shift_q     <= 8'h00;
            rxdata_q    <= 8'h00;
            rxstrobe_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync1_q     <= bus.rx;
            rx_s_q      <= sync1_q;
            rx_prev_q   <= rx_s_q;
            sync_vld_q  <= {sync_vld_q[0], 1'b1};
            armed_q     <= armed_d;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            baud_q      <= baud_d;
            shift_q     <= shift_d;
            rxdata_q    <= rxdata_d;
            rxstrobe_q  <= rxstrobe_d;
            frame_err_q <= frame_err_d;
        end
    end

    // The synchroniser comes out of reset holding 1s, so a line that is
    // still low after reset would otherwise look like a fresh falling edge.
    // Start edges are only accepted once the synchronised line (from real
    // samples, not reset values) has been seen high at least once.
    assign armed_d      = armed_q | (sync_vld_q[1] & rx_s_q);
    assign w_start_edge = armed_q & ~rx_s_q & rx_prev_q;
    assign w_sample     = (state_q != S_IDLE) && (baud_q == '0);

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        baud_d      = baud_q;
        shift_d     = shift_q;
        rxdata_d    = rxdata_q;
        rxstrobe_d  = 1'b0;
        frame_err_d = 1'b0;

        if (state_q != S_IDLE) begin
            baud_d = w_sample ? C_RELOAD : (baud_q - CW'(1));
        end

        case (state_q)
            S_IDLE: begin
                if (w_start_edge) begin
                    state_d = S_START;
                    // Half a period puts every later sample mid-bit.
                    baud_d  = C_HALF;
                end
            end
            S_START: begin
                if (w_sample) begin
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d  = S_DATA;
                        bitcnt_d = 3'd0;
                    end
                end
            end
            S_DATA: begin
                if (w_sample) begin
                    // LSB arrives first: shift in from the top so the first
                    // bit ends up at bit 0 after eight samples.
                    shift_d = {rx_s_q, shift_q[7:1]};
                    if (bitcnt_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (w_sample) begin
                    if (rx_s_q) begin
                        rxdata_d   = shift_q;
                        rxstrobe_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.rxdata    = rxdata_q;
    assign bus.rxstrobe  = rxstrobe_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire
